// File: rtl/st_timing_adt_pkg.sv
// Shared types and helpers for the ST timing FIFO adapter.
// Optional overflow logic is enabled by ST_TIMING_ADT_OVF_EN.
package st_timing_adt_pkg;

  localparam int RL_MAX = 1;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int lvl_w(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/st_timing_fifo_adapter_if.sv
// Streaming bundle between the non-backpressurable source and the sink.
// slave: the adapter's view; master: the driving environment's view.
interface st_timing_fifo_adapter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );
endinterface

// File: rtl/st_timing_adt_ram.sv
// Adapter storage: one write port, one asynchronous read port.
// Kept apart so a registered-read RAM with bypass can replace it.
module st_timing_adt_ram
  import st_timing_adt_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/st_timing_fifo_adapter.sv
// Avalon-ST timing adapter: buffers an unstallable source for a sink
// with ready latency 0 or 1. Sticky overflow under ST_TIMING_ADT_OVF_EN.
module st_timing_fifo_adapter
  import st_timing_adt_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int DEPTH             = 16,
  parameter int OUT_READY_LATENCY = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  st_timing_fifo_adapter_if.slave st,
  output logic [clog2(DEPTH):0]  fill_level,
  output logic                   overflow,
  input  logic                   clear_overflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = lvl_w(DEPTH);

  typedef logic [DATA_WIDTH-1:0] beat_t;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  beat_t         rd_data;

  if (OUT_READY_LATENCY < 0 || OUT_READY_LATENCY > RL_MAX) begin : g_bad_rl
    $error("OUT_READY_LATENCY must be 0 or 1");
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  if (OUT_READY_LATENCY == 0) begin : g_rl0
    assign pop          = st.out_ready & ~empty;
    assign st.out_valid = ~empty;
  end else begin : g_rl1
    logic rdy_d;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) rdy_d <= 1'b0;
      else          rdy_d <= st.out_ready;
    // Valid only where the sink promised acceptance a cycle earlier.
    assign pop          = rdy_d & ~empty;
    assign st.out_valid = pop;
  end

  assign push = st.in_valid & (~full | pop);
  assign drop = st.in_valid & full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  st_timing_adt_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (st.in_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign st.out_data = rd_data;
  assign fill_level  = count;

`ifdef ST_TIMING_ADT_OVF_EN
  // A drop outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)            overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
`else
  logic unused_ovf;
  assign unused_ovf = clear_overflow ^ drop;
  assign overflow   = 1'b0;
`endif

endmodule
